// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: pipeline bundles, bus size codes,
// FSM states and load/store funct3 encodings.
package memory_stage_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    typedef struct packed {
        logic        valid;
        logic        memread;
        logic        memwrite;
        logic [2:0]  funct3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [63:0] result;
        logic [63:0] pc;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        misalign;
        logic [63:0] pc;
    } memory_data_t;

    localparam int EXEC_W = $bits(execute_data_t);
    localparam int MEM_W  = $bits(memory_data_t);

    function automatic msize_t f3_size(input logic [2:0] f3);
        return msize_t'({1'b0, f3[1:0]});
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Lane alignment for the data bus: store strobe/data replication,
// misalignment detection and load shift + extension.
module memory_stage_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [2:0]  size,
    output logic        misalign,
    output logic [7:0]  strobe,
    output logic [63:0] wdata_lane,
    output logic [63:0] rdata_ext
);

    logic [63:0] shifted;
    logic [7:0]  byte_mask;
    logic [2:0]  addr_mask;
    logic        sgn;

    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        sgn        = ~funct3[2];
        size       = f3_size(funct3);
        byte_mask  = 8'h01;
        addr_mask  = 3'b000;
        wdata_lane = {8{wdata[7:0]}};
        rdata_ext  = {{56{sgn & shifted[7]}}, shifted[7:0]};
        unique case (funct3[1:0])
            2'b00: begin
                byte_mask  = 8'h01;
                addr_mask  = 3'b000;
                wdata_lane = {8{wdata[7:0]}};
                rdata_ext  = {{56{sgn & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                byte_mask  = 8'h03;
                addr_mask  = 3'b001;
                wdata_lane = {4{wdata[15:0]}};
                rdata_ext  = {{48{sgn & shifted[15]}}, shifted[15:0]};
            end
            2'b10: begin
                byte_mask  = 8'h0F;
                addr_mask  = 3'b011;
                wdata_lane = {2{wdata[31:0]}};
                rdata_ext  = {{32{sgn & shifted[31]}}, shifted[31:0]};
            end
            2'b11: begin
                byte_mask  = 8'hFF;
                addr_mask  = 3'b111;
                wdata_lane = wdata;
                rdata_ext  = shifted;
            end
            default: ;
        endcase
        misalign = |(addr_lo & addr_mask);
        strobe   = byte_mask << addr_lo;
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives the data bus for loads/stores, stalls until the
// response arrives and hands the result to the writeback register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [EXEC_W-1:0] dataE,
    output logic [MEM_W-1:0]  dataM,
    output logic              stallM,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data
);

    execute_data_t ex;
    memory_data_t  mo;
    mem_state_t    state_q, state_d;
    logic [63:0]   rdata_q, rdata_d;

    logic          is_mem;
    logic          mis;
    logic          mem_op;
    logic          req;
    logic [2:0]    size;
    logic [7:0]    strobe;
    logic [63:0]   wdata_lane;
    logic [63:0]   rdata_ext;

    assign ex = execute_data_t'(dataE);

    memory_stage_align u_align (
        .funct3     (ex.funct3),
        .addr_lo    (ex.addr[2:0]),
        .wdata      (ex.wdata),
        .rdata      (rdata_q),
        .size       (size),
        .misalign   (mis),
        .strobe     (strobe),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    assign is_mem = ex.valid & (ex.memread | ex.memwrite);
    assign mem_op = is_mem & ~mis;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    req = 1'b1;
                    if (dresp_data_ok) begin
                        rdata_d = dresp_data;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dresp_data_ok) begin
                    rdata_d = dresp_data;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Reset gating keeps the bus and writeback quiet during the reset cycle.
    assign stallM      = mem_op & (state_q != DONE) & ~reset;
    assign dreq_valid  = req & ~reset;
    assign dreq_addr   = ex.addr[ADDR_W-1:0];
    assign dreq_size   = size;
    assign dreq_strobe = ex.memwrite ? strobe : 8'h00;
    assign dreq_data   = wdata_lane;

    always_comb begin
        mo.valid    = ex.valid & ~stallM & ~reset;
        mo.rd       = ex.rd;
        mo.result   = (mem_op & ex.memread) ? rdata_ext : ex.result;
        mo.misalign = is_mem & mis;
        mo.pc       = ex.pc;
    end

    assign dataM = mo;

endmodule
